// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, fetch reset vector and the ALU
// function codes that execute flags as branches.
package core_pkg;

    localparam int ADDR_W = 16;
    localparam int INST_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    localparam logic [3:0] BEQ = 4'b0111;
    localparam logic [3:0] BNE = 4'b1000;
    localparam logic [3:0] BLT = 4'b1001;
    localparam logic [3:0] BGT = 4'b1010;

    // Decode/execute use this to raise branch_valid towards fetch.
    function automatic logic is_branch_func(input logic [3:0] func);
        logic hit;
        case (func)
            BEQ, BNE, BLT, BGT: hit = 1'b1;
            default:            hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Fetch buffer: small synchronous FIFO of {pc, instruction} pairs with a
// single-cycle flush used on branch redirect.
module fetch_buf
    import core_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  AW    = ADDR_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [AW-1:0]     push_pc_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [AW-1:0]     head_pc_o,
    output logic [INST_W-1:0] head_inst_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [AW-1:0]     pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok_s, pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == LAST_PTR) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Pointer/count next state; flush overrides any push or pop in the same cycle.
    always_comb begin
        push_ok_s = push_i & ~flush_i & (count_q != DEPTH_C);
        pop_ok_s  = pop_i & ~flush_i & (count_q != '0);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            pc_mem_q[wr_ptr_q]   <= push_pc_i;
            inst_mem_q[wr_ptr_q] <= push_inst_i;
        end
    end

    assign head_pc_o   = pc_mem_q[rd_ptr_q];
    assign head_inst_o = inst_mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory requests, in-order response
// tagging, fetch buffer towards decode, and branch redirect with stale-response drop.
module fetch_unit #(
    parameter int                ADDR_W   = core_pkg::ADDR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = core_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [15:0]       imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [15:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              branch_valid,
    input  logic              do_branch,
    input  logic [ADDR_W-1:0] branch_target
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  o_q, o_d;
    logic [CNT_W-1:0]  d_q, d_d;
    logic [ADDR_W-1:0] tag_mem_q [DEPTH];
    logic [PTR_W-1:0]  tag_rd_q, tag_rd_d;
    logic [PTR_W-1:0]  tag_wr_q, tag_wr_d;

    logic              redirect_s;
    logic [SUM_W-1:0]  occ_s;
    logic              req_valid_s;
    logic              accept_s;
    logic              rsp_push_s;
    logic              pop_s;
    logic              inst_valid_s;
    logic [CNT_W-1:0]  buf_count_s;
    logic [ADDR_W-1:0] buf_pc_s;
    logic [15:0]       buf_inst_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == LAST_PTR) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Handshake decode; occupancy counts both in-flight and buffered work.
    always_comb begin
        redirect_s   = branch_valid & do_branch;
        occ_s        = SUM_W'(o_q) + SUM_W'(buf_count_s);
        req_valid_s  = rst_n & ~redirect_s & (occ_s < DEPTH_S);
        accept_s     = req_valid_s & imem_req_ready;
        rsp_push_s   = imem_rsp_valid & ~redirect_s & (d_q == '0);
        inst_valid_s = rst_n & ~redirect_s & (buf_count_s != '0);
        pop_s        = inst_valid_s & inst_ready;
    end

    // PC, outstanding and discard counters, tag queue pointers.
    always_comb begin
        pc_d     = pc_q;
        o_d      = o_q;
        d_d      = d_q;
        tag_rd_d = tag_rd_q;
        tag_wr_d = tag_wr_q;

        if (redirect_s) begin
            pc_d = branch_target;
        end else if (accept_s) begin
            pc_d = pc_q + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end

        // A response with nothing outstanding belongs to pre-reset traffic.
        case ({accept_s, imem_rsp_valid})
            2'b10:   o_d = o_q + CNT_W'(1);
            2'b01:   o_d = (o_q != '0) ? (o_q - CNT_W'(1)) : o_q;
            default: o_d = o_q;
        endcase

        // Every request still in flight at redirect time is wrong-path.
        if (redirect_s) begin
            d_d = (imem_rsp_valid && (o_q != '0)) ? (o_q - CNT_W'(1)) : o_q;
        end else if (imem_rsp_valid && (d_q != '0)) begin
            d_d = d_q - CNT_W'(1);
        end else begin
            d_d = d_q;
        end

        if (redirect_s) begin
            tag_rd_d = '0;
            tag_wr_d = '0;
        end else begin
            tag_wr_d = accept_s ? ptr_inc(tag_wr_q) : tag_wr_q;
            tag_rd_d = rsp_push_s ? ptr_inc(tag_rd_q) : tag_rd_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            o_q      <= '0;
            d_q      <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            o_q      <= o_d;
            d_q      <= d_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
        end
    end

    // Address of each accepted request, consumed in order by its response.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            tag_mem_q[tag_wr_q] <= pc_q;
        end
    end

    fetch_buf #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rsp_push_s),
        .push_pc_i   (tag_mem_q[tag_rd_q]),
        .push_inst_i (imem_rsp_data),
        .pop_i       (pop_s),
        .flush_i     (redirect_s),
        .head_pc_o   (buf_pc_s),
        .head_inst_o (buf_inst_s),
        .count_o     (buf_count_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_s;
    assign inst_data      = buf_inst_s;
    assign inst_pc        = buf_pc_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency memory model
// and a scoreboard of expected decode-side PCs.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        branch_valid;
    logic        do_branch;
    logic [15:0] branch_target;

    logic        w_req_valid;
    logic [15:0] w_addr;
    logic        w_rsp_valid;
    logic [15:0] w_rsp_data;
    logic        w_inst_valid;
    logic [15:0] w_inst_data;
    logic [15:0] w_inst_pc;

    int          checks = 0;
    int          failures = 0;
    int          mem_lat = 1;
    logic [3:0]  pv;
    logic [15:0] pd [4];
    logic [15:0] exp_q [$];
    logic [15:0] req_log [$];
    logic [15:0] w_pc_log [$];
    logic [15:0] w_data_log [$];
    int          cyc_plain;
    int          cyc_branch;

    always #5 clk = ~clk;

    assign imem_req_ready = 1'b1;
    assign imem_rsp_valid = pv[0];
    assign imem_rsp_data  = pd[0];

    fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .branch_valid   (branch_valid),
        .do_branch      (do_branch),
        .branch_target  (branch_target)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (1'b1),
        .imem_addr      (w_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .inst_valid     (w_inst_valid),
        .inst_ready     (1'b1),
        .inst_data      (w_inst_data),
        .inst_pc        (w_inst_pc),
        .branch_valid   (1'b0),
        .do_branch      (1'b0),
        .branch_target  (16'h0000)
    );

    function automatic logic [15:0] inst_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    // Instruction memory for the main DUT: fixed latency mem_lat, reset with the core.
    always @(posedge clk) begin
        if (!rst_n) begin
            pv <= 4'b0000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                pv[i] <= pv[i+1];
                pd[i] <= pd[i+1];
            end
            pv[3] <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                pv[mem_lat-1] <= 1'b1;
                pd[mem_lat-1] <= inst_of(imem_addr);
            end
        end
    end

    // Single-cycle memory for the wrap-around instance.
    always @(posedge clk) begin
        if (!rst_n) begin
            w_rsp_valid <= 1'b0;
        end else begin
            w_rsp_valid <= w_req_valid;
            w_rsp_data  <= inst_of(w_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic mon();
        logic [15:0] e;
        if (imem_req_valid && imem_req_ready) req_log.push_back(imem_addr);
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_inst_pc", 32'(inst_pc), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", 32'(inst_pc), 32'(e));
                chk("inst_data", 32'(inst_data), 32'(inst_of(e)));
            end
        end
        if (w_inst_valid && (w_pc_log.size() < 4)) begin
            w_pc_log.push_back(w_inst_pc);
            w_data_log.push_back(w_inst_data);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        wait_neg();
        finish_cycle();
    endtask

    task automatic do_reset(input int lat);
        rst_n         = 1'b0;
        inst_ready    = 1'b0;
        branch_valid  = 1'b0;
        do_branch     = 1'b0;
        branch_target = 16'h0000;
        mem_lat       = lat;
        wait_neg();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        finish_cycle();
        tick();
        exp_q.delete();
        req_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_seq(input bit with_branch, output int cycles);
        do_reset(1);
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
        wait_neg();
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", 32'(imem_addr), 32'h0000);
        finish_cycle();
        wait_neg();
        chk("fill_inst_valid", 32'(inst_valid), 32'd0);
        finish_cycle();
        wait_neg();
        chk("first_inst_valid", 32'(inst_valid), 32'd1);
        finish_cycle();
        cycles = 3;
        while ((exp_q.size() != 0) && (cycles < 60)) begin
            if (with_branch && (cycles == 4 || cycles == 5)) begin
                branch_valid  = 1'b1;
                do_branch     = 1'b0;
                branch_target = 16'h0099;
            end else begin
                branch_valid  = 1'b0;
                do_branch     = 1'b0;
            end
            tick();
            cycles++;
        end
        branch_valid = 1'b0;
        inst_ready   = 1'b0;
        chk("seq_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Sequential stream from reset.
        run_seq(1'b0, cyc_plain);

        // Decode stalled: fetch stops at DEPTH, then resumes without loss.
        do_reset(1);
        repeat (6) tick();
        chk("stall_req_count", 32'(req_log.size()), 32'd2);
        chk("stall_req0", 32'(req_log[0]), 32'h0000);
        chk("stall_req1", 32'(req_log[1]), 32'h0001);
        wait_neg();
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        finish_cycle();
        for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
        inst_ready = 1'b1;
        drain("stall_drain", 40);
        chk("resume_req2", 32'(req_log[2]), 32'h0002);
        inst_ready = 1'b0;

        // Back-to-back redirects with two stale requests on a 3-cycle memory.
        do_reset(3);
        tick();
        tick();
        branch_valid  = 1'b1;
        do_branch     = 1'b1;
        branch_target = 16'h0030;
        wait_neg();
        chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        chk("redir_inst_valid", 32'(inst_valid), 32'd0);
        finish_cycle();
        branch_target = 16'h0040;
        wait_neg();
        chk("redir2_req_valid", 32'(imem_req_valid), 32'd0);
        finish_cycle();
        branch_valid = 1'b0;
        do_branch    = 1'b0;
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0041);
        exp_q.push_back(16'h0042);
        inst_ready = 1'b1;
        drain("redir_drain", 60);
        chk("redir_req_target", 32'(req_log[2]), 32'h0040);
        inst_ready = 1'b0;

        // Not-taken branch: same stream and same timing as the plain run.
        run_seq(1'b1, cyc_branch);
        chk("not_taken_cycles", 32'(cyc_branch), 32'(cyc_plain));

        // Reset with work in flight (one buffered, one outstanding).
        do_reset(3);
        repeat (4) tick();
        rst_n = 1'b0;
        wait_neg();
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
        finish_cycle();
        rst_n = 1'b1;
        wait_neg();
        chk("postrst_inst_valid", 32'(inst_valid), 32'd0);
        chk("postrst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("postrst_req_addr", 32'(imem_addr), 32'h0000);
        finish_cycle();
        for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
        inst_ready = 1'b1;
        drain("postrst_drain", 40);
        inst_ready = 1'b0;

        // Wrap-around instance started at 0xFFFE.
        chk("wrap_count", 32'(w_pc_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e;
            e = 16'hFFFE + 16'(i);
            chk("wrap_pc", 32'(w_pc_log[i]), 32'(e));
            chk("wrap_data", 32'(w_data_log[i]), 32'(inst_of(e)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
